// File: rtl/fq_bank.sv
// Multi-channel programmable clock divider with shadowed, glitch-free divisor updates
// and a global in-phase restart.
module fq_bank #(
    parameter int CH       = 4,
    parameter int CNT_LEN  = 8,
    parameter int DEF_DIV  = 2,
    parameter int DEF_HIGH = 1,
    localparam int CH_W    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CH-1:0]      en,
    input  logic               sync,
    input  logic               cfg_wr,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [CNT_LEN-1:0] cfg_div,
    input  logic [CNT_LEN-1:0] cfg_high,
    output logic [CH-1:0]      cfg_busy,
    output logic [CH-1:0]      clk_out,
    output logic [CH-1:0]      tick
);

    localparam logic [CNT_LEN-1:0] ONE = CNT_LEN'(1);

    typedef enum logic {STOP = 1'b0, RUN = 1'b1} state_t;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_t             state, state_nxt;
        logic [CNT_LEN-1:0] cnt, cnt_nxt;
        logic [CNT_LEN-1:0] act_div, act_div_nxt, act_high, act_high_nxt;
        logic [CNT_LEN-1:0] sh_div, sh_div_nxt, sh_high, sh_high_nxt;
        logic               pend, pend_nxt;
        logic               clk_r, clk_nxt, tick_r, tick_nxt;
        logic               wrap, boundary, hit;

        always_comb begin
            state_nxt    = state;
            cnt_nxt      = cnt;
            act_div_nxt  = act_div;
            act_high_nxt = act_high;
            sh_div_nxt   = sh_div;
            sh_high_nxt  = sh_high;
            pend_nxt     = pend;

            // wrap uses the pre-apply divisor so the running period always completes
            wrap     = (state == RUN) && (cnt == act_div - ONE);
            boundary = (state == STOP) || sync || wrap;
            hit      = cfg_wr && (cfg_ch == CH_W'(i));

            if (pend && boundary) begin
                act_div_nxt  = sh_div;
                act_high_nxt = sh_high;
                pend_nxt     = 1'b0;
            end
            // a write landing on an apply edge is held for the next boundary
            if (hit) begin
                sh_div_nxt  = cfg_div;
                sh_high_nxt = cfg_high;
                pend_nxt    = 1'b1;
            end

            if (!en[i] || act_div_nxt == '0) begin
                state_nxt = STOP;
                cnt_nxt   = '0;
            end else if (state == STOP || sync || wrap) begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + ONE;
            end

            clk_nxt  = (state_nxt == RUN) && (cnt_nxt < act_high_nxt);
            tick_nxt = (state_nxt == RUN) && (cnt_nxt == '0);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state    <= STOP;
                cnt      <= '0;
                act_div  <= CNT_LEN'(DEF_DIV);
                act_high <= CNT_LEN'(DEF_HIGH);
                sh_div   <= CNT_LEN'(DEF_DIV);
                sh_high  <= CNT_LEN'(DEF_HIGH);
                pend     <= 1'b0;
                clk_r    <= 1'b0;
                tick_r   <= 1'b0;
            end else begin
                state    <= state_nxt;
                cnt      <= cnt_nxt;
                act_div  <= act_div_nxt;
                act_high <= act_high_nxt;
                sh_div   <= sh_div_nxt;
                sh_high  <= sh_high_nxt;
                pend     <= pend_nxt;
                clk_r    <= clk_nxt;
                tick_r   <= tick_nxt;
            end
        end

        assign clk_out[i]  = clk_r;
        assign tick[i]     = tick_r;
        assign cfg_busy[i] = pend;
    end

endmodule

// File: tb/tb_fq_bank.sv
// Randomized scoreboard bench for fq_bank: a period-position model predicts each
// channel's outputs per clock and a monitor compares them one cycle at a time.
module tb_fq_bank;
    localparam int CH       = 4;
    localparam int CNT_LEN  = 8;
    localparam int DEF_DIV  = 4;
    localparam int DEF_HIGH = 2;
    localparam int CH_W     = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [CH-1:0]      en = '0;
    logic               sync = 1'b0;
    logic               cfg_wr = 1'b0;
    logic [CH_W-1:0]    cfg_ch = '0;
    logic [CNT_LEN-1:0] cfg_div = '0;
    logic [CNT_LEN-1:0] cfg_high = '0;
    logic [CH-1:0]      cfg_busy, clk_out, tick;

    fq_bank #(
        .CH(CH), .CNT_LEN(CNT_LEN), .DEF_DIV(DEF_DIV), .DEF_HIGH(DEF_HIGH)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_busy(cfg_busy),
        .clk_out(clk_out), .tick(tick)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [CH-1:0] clk_o;
        logic [CH-1:0] tick_o;
        logic [CH-1:0] busy;
        string         tag;
    } exp_t;

    exp_t sbq[$];

    // Reference: position within the current period (-1 = stopped), active and
    // shadow settings, and whether a shadow write is waiting.
    int m_pos[CH];
    int m_div[CH];
    int m_high[CH];
    int m_sdiv[CH];
    int m_shigh[CH];
    bit m_pend[CH];

    function automatic void model_reset();
        for (int i = 0; i < CH; i++) begin
            m_pos[i]   = -1;
            m_div[i]   = DEF_DIV;
            m_high[i]  = DEF_HIGH;
            m_sdiv[i]  = DEF_DIV;
            m_shigh[i] = DEF_HIGH;
            m_pend[i]  = 1'b0;
        end
    endfunction

    function automatic exp_t model_step();
        exp_t e;
        for (int i = 0; i < CH; i++) begin
            bit running = (m_pos[i] >= 0);
            bit at_end  = running && (m_pos[i] == m_div[i] - 1);
            if (m_pend[i] && (!running || sync || at_end)) begin
                m_div[i]  = m_sdiv[i];
                m_high[i] = m_shigh[i];
                m_pend[i] = 1'b0;
            end
            if (cfg_wr && int'(cfg_ch) == i) begin
                m_sdiv[i]  = int'(cfg_div);
                m_shigh[i] = int'(cfg_high);
                m_pend[i]  = 1'b1;
            end
            if (!en[i] || m_div[i] == 0) m_pos[i] = -1;
            else if (!running || sync || at_end) m_pos[i] = 0;
            else m_pos[i] = m_pos[i] + 1;
            e.clk_o[i]  = (m_pos[i] >= 0) && (m_pos[i] < m_high[i]);
            e.tick_o[i] = (m_pos[i] == 0);
            e.busy[i]   = m_pend[i];
        end
        return e;
    endfunction

    task automatic step(input string tag);
        exp_t e;
        e = model_step();
        e.tag = tag;
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input int ch, input int div, input int high, input string tag);
        cfg_wr   = 1'b1;
        cfg_ch   = CH_W'(ch);
        cfg_div  = CNT_LEN'(div);
        cfg_high = CNT_LEN'(high);
        step(tag);
        cfg_wr = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        vectors++;
        if (clk_out !== '0 || tick !== '0 || cfg_busy !== '0) begin
            miscompares++;
            $display("FAIL %s clk_out=%b tick=%b busy=%b required all 0", tag, clk_out, tick, cfg_busy);
        end
    endtask

    // Monitor: outputs are presented every cycle, one scoreboard entry per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                vectors++;
                if (clk_out !== e.clk_o || tick !== e.tick_o || cfg_busy !== e.busy) begin
                    miscompares++;
                    $display("FAIL %s t=%0t clk_out=%b tick=%b busy=%b required clk_out=%b tick=%b busy=%b",
                             e.tag, $time, clk_out, tick, cfg_busy, e.clk_o, e.tick_o, e.busy);
                end
            end
        end
    end

    initial begin
        model_reset();
        #12;
        check_zero("reset_state");
        rst = 1'b0;

        en = 4'b0001;
        for (int n = 0; n < 10; n++) step("basic_div4");

        wr(0, 3, 1, "retime_wr");
        for (int n = 0; n < 10; n++) step("retime_run");

        wr(1, 3, 5, "cfg_ch1");
        wr(2, 3, 0, "cfg_ch2");
        wr(3, 1, 1, "cfg_ch3");
        en = 4'b1111;
        for (int n = 0; n < 12; n++) step("const_levels");

        wr(0, 4, 2, "sync_cfg0");
        wr(1, 6, 3, "sync_cfg1");
        en = 4'b0011;
        for (int n = 0; n < 8; n++) step("sync_pre");
        sync = 1'b1;
        step("sync_pulse");
        sync = 1'b0;
        for (int n = 0; n < 8; n++) step("sync_post");

        wr(0, 0, 2, "halt_wr");
        for (int n = 0; n < 6; n++) step("halted");
        wr(0, 5, 2, "restart_wr");
        for (int n = 0; n < 8; n++) step("restarted");

        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 19) == 0) en = CH'($urandom);
            sync = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 5) == 0) begin
                cfg_wr   = 1'b1;
                cfg_ch   = CH_W'($urandom_range(0, CH - 1));
                cfg_div  = ($urandom_range(0, 7) == 0) ? CNT_LEN'($urandom) : CNT_LEN'($urandom_range(0, 9));
                cfg_high = CNT_LEN'($urandom_range(0, 11));
            end else begin
                cfg_wr = 1'b0;
            end
            step("random");
        end
        cfg_wr = 1'b0;
        sync   = 1'b0;

        // Reset asserted between edges with writes pending.
        en = 4'b1111;
        wr(0, 7, 3, "pre_rst_wr0");
        wr(2, 5, 1, "pre_rst_wr2");
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        en  = 4'b0001;
        for (int n = 0; n < 9; n++) step("post_reset_def");

        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fq_bank.md
# fq_bank

Multi-channel programmable frequency divider for the UDAR clock tree. It generates CH independent divided clocks from one system clock, each with its own period and high time. Divisor updates are glitch-free: a new setting takes effect only at the channel's next period boundary. A global sync input restarts every running channel in phase, so sampling and PWM clocks stay aligned. It sits between the system clock and the acquisition/PWM blocks and supersedes the single-channel toggle divider.

## Interface
- CH, 4: number of output channels (≥1).
- CNT_LEN, 8: counter, divisor and high-time width; max period 2^CNT_LEN−1 cycles.
- DEF_DIV, 2: divisor loaded into every channel at reset.
- DEF_HIGH, 1: high time loaded into every channel at reset.
- clk  in  1  system clock; all logic on posedge only.
- rst  in  1  reset, asynchronous, active-high.
- en  in  CH  per-channel run enable.
- sync  in  1  restart all enabled channels at period start.
- cfg_wr  in  1  write strobe for one channel's shadow settings.
- cfg_ch  in  $clog2(CH) (min 1)  target channel of cfg_wr.
- cfg_div  in  CNT_LEN  new period in cycles; 0 = channel halted.
- cfg_high  in  CNT_LEN  new high time in cycles.
- cfg_busy  out  CH  shadow write pending, not yet applied.
- clk_out  out  CH  divided clock, registered.
- tick  out  CH  one-cycle strobe on the first cycle of each period, registered.

## Operation
- Per channel: active regs act_div/act_high, shadow regs sh_div/sh_high, counter cnt (CNT_LEN bits), run flag, pending flag.
- States per channel: STOP (run=0) and RUN (run=1).
- Config: cfg_wr with cfg_ch<CH loads the shadow regs and sets pending. A write to a pending channel overwrites the shadow; last write wins. cfg_ch≥CH is ignored.
- Apply rule: pending shadow is copied to active at every period start and on every STOP-state edge, then pending clears. Gives glitch-free updates.
- Each edge, evaluated in priority order:
  - en[i]=0 or act_div=0 (after apply): STOP. cnt←0, run←0, clk_out←0, tick←0.
  - en[i]=1 and (run=0 or sync=1): period start. cnt←0, run←1.
  - run=1 and cnt=act_div−1: period start, cnt←0.
  - Otherwise cnt←cnt+1.
- In RUN: clk_out←(new cnt < act_high) and tick←(new cnt = 0), both using post-apply active values. act_high≥act_div gives constant 1; act_high=0 gives constant 0; tick still runs in both cases.
- act_div=1: cnt stays 0, tick=1 every cycle, clk_out=(act_high≠0).
- cfg_busy[i]=pending[i].

## Timing
- Reset (async): cnt=0, run=0, pending=0, act/sh=DEF_DIV/DEF_HIGH, clk_out=0, tick=0, cfg_busy=0.
- First enabled edge after reset or after en rises: period start, so tick=1 and clk_out=(act_high≠0) on that edge. Latency is 1 clock from en.
- Period = act_div clocks; high time = min(act_high, act_div) clocks.
- cfg_wr on edge E sets cfg_busy after E. The shadow applies at the first period start strictly after E, never on E itself, even if E is a boundary. cfg_busy falls on that apply edge.
- cfg_wr and apply on the same edge for the same channel: the old shadow applies and the new write is captured with pending=1.
- sync on edge E: all running channels read cnt=0 and tick=1 after E; pending shadows apply on E. Channels in STOP ignore sync.
- en deasserted mid-period: clk_out=0 and tick=0 on the next edge; no partial-period completion.
- rst asserted mid-operation: outputs go to reset values immediately without waiting for a clock edge; pending writes are lost.

## Test plan
- DEF_DIV=4, DEF_HIGH=2; release rst, en=4'b0001 → ch0 clk_out 1,1,0,0 repeating; tick on each first cycle; other channels hold 0.
- ch0 running div=4/high=2; write div=3/high=1 at cnt=1 → current period finishes at 4 cycles, then 1,0,0 repeating; cfg_busy[0] high exactly until the apply edge.
- Channel configs high=5/div=3 and high=0/div=3 → clk_out constant 1 and constant 0 respectively; tick every 3 cycles on both. div=1 → tick every cycle.
- ch0 div=4, ch1 div=6 running, pulse sync → both tick on the next edge and their period starts realign; STOP channel stays 0.
- Write div=0 to a running channel → halts at the boundary with outputs 0. Then write div=5 → restarts on the next edge with tick=1.
- Assert rst mid-period between clock edges → clk_out, tick and cfg_busy reach 0 before the next edge; after release, DEF values apply.
